johnson_seq_ctrl: RTL and testbench

Sequencing controller for an N-stage Johnson (twisted-ring) counter. It owns the counter register and runs it for a programmed number of full revolutions (2N states each) in a selected direction, with pause, abort and completion handshake. It decodes the current state to a phase index and a one-hot phase vector for downstream multi-phase timing logic.

---
 rtl/johnson_seq_pkg.sv | 11 +
 rtl/johnson_core.sv | 27 ++
 rtl/johnson_seq_ctrl.sv | 89 ++++++++
 tb/tb_johnson_seq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/johnson_seq_pkg.sv
// johnson_seq_pkg: shared FSM state encoding and direction constants
package johnson_seq_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/johnson_core.sv
// johnson_core: N-stage Johnson register with enable, direction and synchronous clear
module johnson_core
    import johnson_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_dir,
    input  logic         i_sclr,
    output logic [N-1:0] o_q
);
    logic [N-1:0] r_q;
    logic [N-1:0] w_q_next;

    always_comb w_q_next = (i_dir == DIR_DN) ? {~r_q[0], r_q[N-1:1]} : {r_q[N-2:0], ~r_q[N-1]};

    always_ff @(posedge i_clk) begin
        if (!i_clr || i_sclr)
            r_q <= '0;
        else if (i_en)
            r_q <= w_q_next;
    end

    assign o_q = r_q;
endmodule

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: runs a Johnson counter for a programmed number of revolutions
// with pause/abort, completion pulse and phase decode.
module johnson_seq_ctrl
    import johnson_seq_pkg::*;
#(
    parameter int N       = 4,
    parameter int LOOPS_W = 8,
    localparam int IW     = $clog2(2 * N)
) (
    input  logic               i_clk,
    input  logic               i_clr,
    input  logic               i_start,
    input  logic [LOOPS_W-1:0] i_loops,
    input  logic               i_dir,
    input  logic               i_pause,
    input  logic               i_stop,
    output logic               o_busy,
    output logic               o_done,
    output logic [N-1:0]       o_q,
    output logic [IW-1:0]      o_phase_idx,
    output logic [2*N-1:0]     o_phase,
    output logic [LOOPS_W-1:0] o_rev_cnt
);
    localparam logic [N-1:0] Q_UP_LAST = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] Q_DN_LAST = {{(N-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_next;
    logic [LOOPS_W-1:0] r_loops, r_rev_cnt, w_rev_inc;
    logic               r_dir;
    logic               w_accept, w_adv, w_wrap, w_sclr;
    logic [N-1:0]       w_q;
    int                 w_pop;

    assign w_accept  = (r_state == ST_IDLE) && i_start;
    assign w_adv     = (r_state == ST_RUN) && !i_stop && !i_pause;
    // The state just before all-zeros is the only one whose advance wraps
    assign w_wrap    = w_adv && (w_q == ((r_dir == DIR_DN) ? Q_DN_LAST : Q_UP_LAST));
    assign w_rev_inc = r_rev_cnt + LOOPS_W'(1);
    assign w_sclr    = i_stop && ((r_state == ST_RUN) || (r_state == ST_HOLD));

    johnson_core #(.N(N)) u_core (
        .i_clk  (i_clk),
        .i_clr  (i_clr),
        .i_en   (w_adv),
        .i_dir  (r_dir),
        .i_sclr (w_sclr),
        .o_q    (w_q)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = i_start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_state_next = i_stop ? ST_IDLE : i_pause ? ST_HOLD :
                                    (w_wrap && r_loops != '0 && w_rev_inc == r_loops) ? ST_DONE : ST_RUN;
            ST_HOLD: w_state_next = i_stop ? ST_IDLE : i_pause ? ST_HOLD : ST_RUN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state   <= ST_IDLE;
            r_loops   <= '0;
            r_dir     <= DIR_UP;
            r_rev_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_rev_cnt <= w_accept ? '0 : w_wrap ? w_rev_inc : r_rev_cnt;
            if (w_accept) begin
                r_loops <= i_loops;
                r_dir   <= i_dir;
            end
        end
    end

    always_comb begin
        w_pop = 0;
        for (int i = 0; i < N; i++)
            w_pop = w_pop + int'(w_q[i]);
    end

    assign o_phase_idx = IW'(w_q[N-1] ? 2 * N - w_pop : w_pop);
    assign o_phase     = (2 * N)'(1) << o_phase_idx;
    assign o_q         = w_q;
    assign o_busy      = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign o_done      = (r_state == ST_DONE);
    assign o_rev_cnt   = r_rev_cnt;
endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// tb_johnson_seq_ctrl: table vectors, directed corner sequences and random stimulus
// against a position-based reference model.
module tb_johnson_seq_ctrl;
    localparam int N = 4;
    localparam int S = 2 * N;

    logic       clk = 1'b0;
    logic       clr = 1'b0, start = 1'b0, dir = 1'b0, pause = 1'b0, stop = 1'b0;
    logic [7:0] loops = 8'd0;
    logic       busy, done;
    logic [3:0] q;
    logic [2:0] pidx;
    logic [7:0] phase, rev;

    always #5 clk = ~clk;

    johnson_seq_ctrl #(.N(N), .LOOPS_W(8)) dut (
        .i_clk       (clk),
        .i_clr       (clr),
        .i_start     (start),
        .i_loops     (loops),
        .i_dir       (dir),
        .i_pause     (pause),
        .i_stop      (stop),
        .o_busy      (busy),
        .o_done      (done),
        .o_q         (q),
        .o_phase_idx (pidx),
        .o_phase     (phase),
        .o_rev_cnt   (rev)
    );

    int n_chk = 0, n_pass = 0;
    // model: mode 0 idle, 1 running, 2 paused, 3 finished; position on the ring 0..S-1
    int m_mode = 0, m_idx = 0, m_rev = 0, m_loops = 0, m_dir = 0;

    typedef struct {
        logic       clr, start;
        logic [7:0] loops;
        logic       dir, pause, stop;
        logic [3:0] q;
        logic       busy, done;
        logic [7:0] rev;
    } vec_t;
    vec_t tbl[17];

    function automatic logic [3:0] qof(int k);
        if (k <= N) return 4'((1 << k) - 1);
        return 4'(((1 << N) - 1) & ~((1 << (k - N)) - 1));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model(logic c, logic s, logic [7:0] l, logic d, logic p, logic t);
        if (!c) begin
            m_mode = 0; m_idx = 0; m_rev = 0; m_loops = 0; m_dir = 0;
        end else if (m_mode == 0) begin
            if (s) begin m_mode = 1; m_loops = l; m_dir = d; m_rev = 0; end
        end else if (m_mode == 1) begin
            if (t) begin m_mode = 0; m_idx = 0; end
            else if (p) m_mode = 2;
            else begin
                m_idx = m_dir ? (m_idx + S - 1) % S : (m_idx + 1) % S;
                if (m_idx == 0) begin
                    m_rev = (m_rev + 1) % 256;
                    if (m_loops != 0 && m_rev == m_loops) m_mode = 3;
                end
            end
        end else if (m_mode == 2) begin
            if (t) begin m_mode = 0; m_idx = 0; end
            else if (!p) m_mode = 1;
        end else m_mode = 0;
    endtask

    task automatic step(string name, logic c, logic s, logic [7:0] l, logic d, logic p, logic t);
        @(negedge clk);
        clr = c; start = s; loops = l; dir = d; pause = p; stop = t;
        @(posedge clk);
        #1;
        model(c, s, l, d, p, t);
        chk(name, {busy, done, q, pidx, phase, rev},
            {(m_mode == 1 || m_mode == 2), (m_mode == 3), qof(m_idx), 3'(m_idx), 8'(1 << m_idx), 8'(m_rev)});
    endtask

    task automatic idle(string name, int n);
        for (int i = 0; i < n; i++) step(name, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [3:0] dn_q[8];
        int cnt, seen;
        dn_q = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 0, 0, 4'h0, 1, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0, 4'h1, 1, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 4'h3, 1, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 4'h7, 1, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 4'hF, 1, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 4'hE, 1, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 4'hC, 1, 0, 0};
        tbl[8]  = '{1, 0, 0, 0, 0, 0, 4'h8, 1, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1};
        tbl[11] = '{1, 1, 3, 0, 0, 0, 4'h0, 1, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 4'h1, 1, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 4'h3, 1, 0, 0};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 4'h7, 1, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            step($sformatf("model_tbl%0d", i), tbl[i].clr, tbl[i].start, tbl[i].loops,
                 tbl[i].dir, tbl[i].pause, tbl[i].stop);
            chk($sformatf("tbl%0d", i), {q, busy, done, rev}, {tbl[i].q, tbl[i].busy, tbl[i].done, tbl[i].rev});
        end
        chk("reset_phase", phase, 8'b0000_0001);

        // two revolutions down
        step("dn_start", 1, 1, 2, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            step("dn_run", 1, 0, 0, 0, 0, 0);
            chk($sformatf("dn_q%0d", i), q, dn_q[i % 8]);
            if (i == 7) chk("dn_rev1", {rev, busy}, {8'd1, 1'b1});
        end
        chk("dn_done", {done, rev}, {1'b1, 8'd2});
        idle("dn_idle", 1);
        chk("dn_after", {busy, done}, 2'b00);

        // pause at 0111
        step("ps_start", 1, 1, 1, 0, 0, 0);
        idle("ps_run", 3);
        for (int i = 0; i < 3; i++) begin
            step("ps_hold", 1, 0, 0, 0, 1, 0);
            chk("ps_frozen", {q, busy}, {4'h7, 1'b1});
        end
        idle("ps_resume", 1);
        chk("ps_resume_q", q, 4'h7);
        idle("ps_adv", 1);
        chk("ps_adv_q", q, 4'hF);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            idle("ps_tail", 1);
            seen = int'(done);
        end
        chk("ps_done_seen", seen, 1);
        idle("ps_idle", 1);

        // start during RUN is ignored
        step("ig_start", 1, 1, 2, 0, 0, 0);
        idle("ig_run", 3);
        step("ig_restart", 1, 1, 5, 0, 0, 0);
        cnt = 4;
        while (!done && cnt < 40) begin
            idle("ig_tail", 1);
            cnt++;
        end
        chk("ig_done_edge", cnt, 16);
        chk("ig_rev", rev, 8'd2);
        idle("ig_idle", 1);

        // abort with stop and pause together at 1110
        step("ab_start", 1, 1, 1, 0, 0, 0);
        idle("ab_run", 5);
        chk("ab_pre_q", q, 4'hE);
        step("ab_stop", 1, 0, 0, 0, 1, 1);
        chk("ab_after", {q, busy, done}, {4'h0, 1'b0, 1'b0});
        idle("ab_idle", 1);
        chk("ab_no_done", done, 1'b0);

        // free-run
        step("fr_start", 1, 1, 0, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            idle("fr_run", 1);
            seen = seen | int'(done);
        end
        chk("fr_rev3", {rev, busy}, {8'd3, 1'b1});
        chk("fr_no_done", seen, 0);
        step("fr_stop", 1, 0, 0, 0, 0, 1);
        chk("fr_stopped", {busy, done, rev}, {1'b0, 1'b0, 8'd3});

        for (int i = 0; i < 800; i++)
            step("rnd", $urandom_range(31) != 0, $urandom_range(5) == 0, 8'($urandom_range(3)),
                 1'($urandom), $urandom_range(5) == 0, $urandom_range(19) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
